// File: rtl/mem_data_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port data memory.
// Each granted request takes one memory cycle, then returns a one-cycle response.
module mem_data_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TAM        = 32,
  parameter int unsigned ADDRESSLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0ReqValid,
  output logic                  m0ReqReady,
  input  logic                  m0ReqWrite,
  input  logic [ADDRESSLEN-1:0] m0ReqAddress,
  input  logic [XLEN-1:0]       m0ReqData,
  output logic                  m0RespValid,
  output logic [XLEN-1:0]       m0RespData,
  output logic                  m0RespError,
  input  logic                  m1ReqValid,
  output logic                  m1ReqReady,
  input  logic                  m1ReqWrite,
  input  logic [ADDRESSLEN-1:0] m1ReqAddress,
  input  logic [XLEN-1:0]       m1ReqData,
  output logic                  m1RespValid,
  output logic [XLEN-1:0]       m1RespData,
  output logic                  m1RespError,
  output logic [ADDRESSLEN-1:0] memWriteAddress,
  output logic [ADDRESSLEN-1:0] memReadAddress,
  output logic [XLEN-1:0]       memData,
  output logic                  memWriteEnabled,
  output logic                  memReadEnabled,
  input  logic [XLEN-1:0]       memOut
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [ADDRESSLEN-3:0] TamWord = (ADDRESSLEN-2)'(TAM);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic                  write_q, write_d;
  logic [ADDRESSLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic                  err_q, err_d;
  logic [XLEN-1:0]       resp_data_q, resp_data_d;

  logic                  grant_owner;
  logic                  handshake;
  logic                  legal;
  logic                  req_write;
  logic [ADDRESSLEN-1:0] req_addr;
  logic [XLEN-1:0]       req_data;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_owner = (m0ReqValid && m1ReqValid) ? ~last_grant_q : m1ReqValid;
    m0ReqReady  = (state_q == StIdle) && m0ReqValid && !grant_owner;
    m1ReqReady  = (state_q == StIdle) && m1ReqValid && grant_owner;
    handshake   = m0ReqReady || m1ReqReady;
    req_write   = grant_owner ? m1ReqWrite   : m0ReqWrite;
    req_addr    = grant_owner ? m1ReqAddress : m0ReqAddress;
    req_data    = grant_owner ? m1ReqData    : m0ReqData;
    legal       = (req_addr[1:0] == 2'b00) && (req_addr[ADDRESSLEN-1:2] < TamWord);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      err_q        <= err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    write_d      = write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    err_d        = err_q;
    resp_data_d  = resp_data_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          owner_d      = grant_owner;
          last_grant_d = grant_owner;
          write_d      = req_write;
          addr_d       = req_addr;
          data_d       = req_data;
          err_d        = !legal;
          resp_data_d  = '0;
          state_d      = legal ? StAccess : StResp;
        end
      end
      StAccess: begin
        resp_data_d = write_q ? '0 : memOut;
        state_d     = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory address/data hold the last command; only the enables are gated by state.
  always_comb begin
    memWriteAddress = addr_q;
    memReadAddress  = addr_q;
    memData         = data_q;
    memWriteEnabled = (state_q == StAccess) && write_q;
    memReadEnabled  = (state_q == StAccess) && !write_q;
    m0RespValid     = 1'b0;
    m0RespError     = 1'b0;
    m0RespData      = '0;
    m1RespValid     = 1'b0;
    m1RespError     = 1'b0;
    m1RespData      = '0;
    if (state_q == StResp) begin
      if (owner_q) begin
        m1RespValid = 1'b1;
        m1RespError = err_q;
        m1RespData  = resp_data_q;
      end else begin
        m0RespValid = 1'b1;
        m0RespError = err_q;
        m0RespData  = resp_data_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Directed bench for mem_data_arbiter with a behavioural memory (posedge write, negedge read).
module tb_mem_data_arbiter;

  localparam int unsigned TAM = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0ReqValid = 1'b0, m0ReqWrite = 1'b0;
  logic [31:0] m0ReqAddress = '0, m0ReqData = '0;
  logic        m1ReqValid = 1'b0, m1ReqWrite = 1'b0;
  logic [31:0] m1ReqAddress = '0, m1ReqData = '0;
  logic        m0ReqReady, m0RespValid, m0RespError;
  logic        m1ReqReady, m1RespValid, m1RespError;
  logic [31:0] m0RespData, m1RespData;
  logic [31:0] memWriteAddress, memReadAddress, memData;
  logic        memWriteEnabled, memReadEnabled;
  logic [31:0] memOut = '0;

  logic [31:0] mem [TAM] = '{default: 32'h0};

  int tests = 0;
  int fails = 0;
  int we_cnt = 0, re_cnt = 0, r0_cnt = 0, r1_cnt = 0, viol = 0;

  always #5 clk = ~clk;

  mem_data_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0ReqValid     (m0ReqValid),
    .m0ReqReady     (m0ReqReady),
    .m0ReqWrite     (m0ReqWrite),
    .m0ReqAddress   (m0ReqAddress),
    .m0ReqData      (m0ReqData),
    .m0RespValid    (m0RespValid),
    .m0RespData     (m0RespData),
    .m0RespError    (m0RespError),
    .m1ReqValid     (m1ReqValid),
    .m1ReqReady     (m1ReqReady),
    .m1ReqWrite     (m1ReqWrite),
    .m1ReqAddress   (m1ReqAddress),
    .m1ReqData      (m1ReqData),
    .m1RespValid    (m1RespValid),
    .m1RespData     (m1RespData),
    .m1RespError    (m1RespError),
    .memWriteAddress(memWriteAddress),
    .memReadAddress (memReadAddress),
    .memData        (memData),
    .memWriteEnabled(memWriteEnabled),
    .memReadEnabled (memReadEnabled),
    .memOut         (memOut)
  );

  always @(posedge clk) if (memWriteEnabled) mem[memWriteAddress[6:2]] <= memData;
  always @(negedge clk) if (memReadEnabled) memOut <= mem[memReadAddress[6:2]];

  // Continuous protocol watch: idle responses must be zero, one owner at a time.
  always @(negedge clk) begin
    if (memWriteEnabled) we_cnt <= we_cnt + 1;
    if (memReadEnabled) re_cnt <= re_cnt + 1;
    if (m0RespValid) r0_cnt <= r0_cnt + 1;
    if (m1RespValid) r1_cnt <= r1_cnt + 1;
    if ((!m0RespValid && (m0RespData != 0 || m0RespError)) ||
        (!m1RespValid && (m1RespData != 0 || m1RespError)) ||
        (m0RespValid && m1RespValid) || (memWriteEnabled && memReadEnabled))
      viol <= viol + 1;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives a request and holds it until the handshake edge; returns one cycle after it.
  task automatic issue(input bit m, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, output bit ok);
    if (m) begin
      m1ReqValid = 1'b1; m1ReqWrite = wr; m1ReqAddress = addr; m1ReqData = wdata;
    end else begin
      m0ReqValid = 1'b1; m0ReqWrite = wr; m0ReqAddress = addr; m0ReqData = wdata;
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (m ? m1ReqReady : m0ReqReady) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (m) m1ReqValid = 1'b0;
    else m0ReqValid = 1'b0;
  endtask

  task automatic wait_resp(input bit m, output int lat, output logic err,
                           output logic [31:0] d);
    lat = 1;
    while (!(m ? m1RespValid : m0RespValid) && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    err = m ? m1RespError : m0RespError;
    d   = m ? m1RespData : m0RespData;
  endtask

  task automatic test_reset();
    cycles(3);
    tests++;
    if ({m0ReqReady, m1ReqReady, m0RespValid, m1RespValid, m0RespError, m1RespError,
         memWriteEnabled, memReadEnabled} !== 8'h0) begin
      fails++; $display("FAIL reset_ctrl: got nonzero control outputs, required 0");
    end
    tests++;
    if ({m0RespData, m1RespData, memData, memWriteAddress, memReadAddress} !== 160'h0) begin
      fails++; $display("FAIL reset_data: got nonzero data/address outputs, required 0");
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
  endtask

  task automatic test_reset_mid_access();
    bit ok; int lat; logic err; logic [31:0] d; int r0_snap;
    issue(1'b0, 1'b1, 32'h8, 32'h1111_1111, ok);
    tests++;
    if (!ok || memWriteEnabled !== 1'b1 || memWriteAddress !== 32'h8) begin
      fails++; $display("FAIL rst_mid_access: ok=%0b we=%b addr=%h, required 1 1 00000008",
                        ok, memWriteEnabled, memWriteAddress);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({memWriteEnabled, memReadEnabled, m0RespValid, m0ReqReady} !== 4'h0 ||
        memWriteAddress !== 32'h0 || memData !== 32'h0) begin
      fails++; $display("FAIL rst_mid_zero: we=%b addr=%h data=%h, required 0 0 0",
                        memWriteEnabled, memWriteAddress, memData);
    end
    r0_snap = r0_cnt;
    cycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(4);
    tests++;
    if (r0_cnt !== r0_snap) begin
      fails++; $display("FAIL rst_mid_noresp: got %0d responses, required 0", r0_cnt - r0_snap);
    end
    issue(1'b1, 1'b0, 32'h8, 32'h0, ok);
    wait_resp(1'b1, lat, err, d);
    tests++;
    if (!ok || lat !== 2 || err !== 1'b0 || d !== 32'h0) begin
      fails++; $display("FAIL rst_mid_m1load: ok=%0b lat=%0d err=%b data=%h, required 1 2 0 0",
                        ok, lat, err, d);
    end
    cycles(2);
  endtask

  task automatic test_round_robin();
    int g = 0; int cyc = 0; int order[4]; int when[4]; int r0_snap, r1_snap;
    r0_snap = r0_cnt; r1_snap = r1_cnt;
    m0ReqValid = 1'b1; m0ReqWrite = 1'b0; m0ReqAddress = 32'h0;
    m1ReqValid = 1'b1; m1ReqWrite = 1'b0; m1ReqAddress = 32'h4;
    while (g < 4 && cyc < 40) begin
      #1;
      if (m0ReqReady && m1ReqReady) begin
        order[g] = 2; when[g] = cyc; g++;
      end else if (m0ReqReady) begin
        order[g] = 0; when[g] = cyc; g++;
      end else if (m1ReqReady) begin
        order[g] = 1; when[g] = cyc; g++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    m0ReqValid = 1'b0; m1ReqValid = 1'b0;
    cycles(4);
    tests++;
    if (g !== 4) begin
      fails++; $display("FAIL rr_grants: got %0d grants, required 4", g);
    end else begin
      tests++;
      if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1) begin
        fails++; $display("FAIL rr_order: got %0d%0d%0d%0d, required 0101",
                          order[0], order[1], order[2], order[3]);
      end
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (when[k+1] - when[k] !== 3) begin
          fails++; $display("FAIL rr_spacing%0d: got %0d cycles, required 3",
                            k, when[k+1] - when[k]);
        end
      end
    end
    tests++;
    if (r0_cnt - r0_snap !== 2 || r1_cnt - r1_snap !== 2) begin
      fails++; $display("FAIL rr_resps: got m0=%0d m1=%0d, required 2 2",
                        r0_cnt - r0_snap, r1_cnt - r1_snap);
    end
  endtask

  task automatic test_store_load();
    bit ok; int lat; logic err; logic [31:0] d; int we_snap, re_snap;
    we_snap = we_cnt; re_snap = re_cnt;
    issue(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, ok);
    tests++;
    if (memWriteAddress !== 32'h10 || memReadAddress !== 32'h10 || memData !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL st_memport: waddr=%h raddr=%h data=%h, required 10 10 deadbeef",
                        memWriteAddress, memReadAddress, memData);
    end
    wait_resp(1'b0, lat, err, d);
    tests++;
    if (!ok || lat !== 2 || err !== 1'b0 || d !== 32'h0) begin
      fails++; $display("FAIL st_resp: ok=%0b lat=%0d err=%b data=%h, required 1 2 0 0",
                        ok, lat, err, d);
    end
    cycles(1);
    tests++;
    if (we_cnt - we_snap !== 1 || re_cnt - re_snap !== 0) begin
      fails++; $display("FAIL st_enables: got we=%0d re=%0d, required 1 0",
                        we_cnt - we_snap, re_cnt - re_snap);
    end
    we_snap = we_cnt; re_snap = re_cnt;
    issue(1'b0, 1'b0, 32'h10, 32'h0, ok);
    wait_resp(1'b0, lat, err, d);
    tests++;
    if (!ok || lat !== 2 || err !== 1'b0 || d !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL ld_resp: ok=%0b lat=%0d err=%b data=%h, required 1 2 0 deadbeef",
                        ok, lat, err, d);
    end
    cycles(1);
    tests++;
    if (we_cnt - we_snap !== 0 || re_cnt - re_snap !== 1) begin
      fails++; $display("FAIL ld_enables: got we=%0d re=%0d, required 0 1",
                        we_cnt - we_snap, re_cnt - re_snap);
    end
  endtask

  task automatic test_misaligned();
    bit ok; int lat; logic err; logic [31:0] d; int re_snap;
    re_snap = re_cnt;
    issue(1'b1, 1'b0, 32'h6, 32'h0, ok);
    wait_resp(1'b1, lat, err, d);
    tests++;
    if (!ok || lat !== 1 || err !== 1'b1 || d !== 32'h0) begin
      fails++; $display("FAIL misaligned: ok=%0b lat=%0d err=%b data=%h, required 1 1 1 0",
                        ok, lat, err, d);
    end
    cycles(1);
    tests++;
    if (re_cnt !== re_snap) begin
      fails++; $display("FAIL misaligned_noread: got %0d reads, required 0", re_cnt - re_snap);
    end
  endtask

  task automatic test_out_of_range();
    bit ok; int lat; logic err; logic [31:0] d; int we_snap;
    issue(1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5, ok);
    wait_resp(1'b0, lat, err, d);
    cycles(1);
    we_snap = we_cnt;
    issue(1'b0, 1'b1, 32'h80, 32'h1234_5678, ok);
    wait_resp(1'b0, lat, err, d);
    tests++;
    if (!ok || lat !== 1 || err !== 1'b1 || d !== 32'h0) begin
      fails++; $display("FAIL oor_store: ok=%0b lat=%0d err=%b data=%h, required 1 1 1 0",
                        ok, lat, err, d);
    end
    cycles(1);
    tests++;
    if (we_cnt !== we_snap) begin
      fails++; $display("FAIL oor_nowrite: got %0d writes, required 0", we_cnt - we_snap);
    end
    issue(1'b1, 1'b0, 32'h1000_0000, 32'h0, ok);
    wait_resp(1'b1, lat, err, d);
    tests++;
    if (!ok || lat !== 1 || err !== 1'b1) begin
      fails++; $display("FAIL oor_high: ok=%0b lat=%0d err=%b, required 1 1 1", ok, lat, err);
    end
    cycles(1);
    issue(1'b0, 1'b0, 32'h0, 32'h0, ok);
    wait_resp(1'b0, lat, err, d);
    tests++;
    if (!ok || lat !== 2 || err !== 1'b0 || d !== 32'hA5A5_A5A5) begin
      fails++; $display("FAIL oor_word0: ok=%0b lat=%0d err=%b data=%h, required 1 2 0 a5a5a5a5",
                        ok, lat, err, d);
    end
    cycles(1);
  endtask

  task automatic test_contention();
    bit ok; int lat; logic err; logic [31:0] d;
    issue(1'b0, 1'b0, 32'h10, 32'h0, ok);
    m1ReqValid = 1'b1; m1ReqWrite = 1'b0; m1ReqAddress = 32'h0;
    #1;
    tests++;
    if (!ok || m1ReqReady !== 1'b0) begin
      fails++; $display("FAIL busy_access: ok=%0b m1ReqReady=%b, required 1 0", ok, m1ReqReady);
    end
    cycles(1);
    tests++;
    if (m1ReqReady !== 1'b0 || m0RespValid !== 1'b1 || m0RespData !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL busy_resp: m1rdy=%b m0v=%b m0d=%h, required 0 1 deadbeef",
                        m1ReqReady, m0RespValid, m0RespData);
    end
    cycles(1);
    tests++;
    if (m1ReqReady !== 1'b1) begin
      fails++; $display("FAIL busy_idle_grant: m1ReqReady=%b, required 1", m1ReqReady);
    end
    issue(1'b1, 1'b0, 32'h0, 32'h0, ok);
    wait_resp(1'b1, lat, err, d);
    tests++;
    if (!ok || lat !== 2 || err !== 1'b0 || d !== 32'hA5A5_A5A5) begin
      fails++; $display("FAIL busy_m1load: ok=%0b lat=%0d err=%b data=%h, required 1 2 0 a5a5a5a5",
                        ok, lat, err, d);
    end
    cycles(2);
  endtask

  initial begin
    test_reset();
    test_reset_mid_access();
    test_round_robin();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_contention();
    tests++;
    if (viol !== 0) begin
      fails++; $display("FAIL protocol_watch: got %0d violations, required 0", viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
